// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with flush-to-handler, stall bubble/hold and RI exception substitution.
// Optional statistics counters are enabled by defining PIPE_STAGE_STAT_EN.
module pipe_stage_reg #(
  parameter int unsigned PAYLOAD_W     = 128,
  parameter bit          HOLD_ON_STALL = 1'b0,
  parameter logic [31:0] HANDLER_PC    = 32'h0000_4180,
  parameter logic [4:0]  RI_CODE       = 5'd10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 stall,
  input  logic                 in_valid,
  input  logic [31:0]          in_pc,
  input  logic [31:0]          in_instr,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [4:0]           in_exc,
  input  logic                 in_ri,
  input  logic                 in_bd,
  output logic                 out_valid,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_instr,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [4:0]           out_exc,
  output logic                 out_bd,
  output logic [31:0]          stat_bubble,
  output logic [31:0]          stat_flush
);

  logic                 valid_q, valid_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          instr_q, instr_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [4:0]           exc_q, exc_d;
  logic                 bd_q, bd_d;

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    payload_d = payload_q;
    exc_d     = exc_q;
    bd_d      = bd_q;
    if (req) begin
      valid_d   = 1'b0;
      pc_d      = HANDLER_PC;
      instr_d   = '0;
      payload_d = '0;
      exc_d     = '0;
      bd_d      = 1'b0;
    end else if (stall) begin
      if (!HOLD_ON_STALL) begin
        // Bubble keeps PC and BD so a later exception can still form EPC.
        valid_d   = 1'b0;
        pc_d      = in_pc;
        instr_d   = '0;
        payload_d = '0;
        exc_d     = '0;
        bd_d      = in_bd;
      end
    end else begin
      valid_d   = in_valid;
      pc_d      = in_pc;
      payload_d = in_payload;
      bd_d      = in_bd;
      instr_d   = '0;
      exc_d     = '0;
      // Earlier-stage exception outranks RI; any exception squashes the instruction.
      if (in_valid) begin
        if (in_exc != 5'd0) begin
          exc_d = in_exc;
        end else if (in_ri) begin
          exc_d = RI_CODE;
        end else begin
          instr_d = in_instr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      instr_q   <= '0;
      payload_q <= '0;
      exc_q     <= '0;
      bd_q      <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      payload_q <= payload_d;
      exc_q     <= exc_d;
      bd_q      <= bd_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_instr   = instr_q;
  assign out_payload = payload_q;
  assign out_exc     = exc_q;
  assign out_bd      = bd_q;

`ifdef PIPE_STAGE_STAT_EN
  logic        bubble_ev, flush_ev;
  logic [31:0] bubble_cnt_q, flush_cnt_q;

  assign flush_ev  = req;
  assign bubble_ev = !req && ((stall && !HOLD_ON_STALL) || (!stall && !in_valid));

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (bubble_ev) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (flush_ev)  flush_cnt_q  <= flush_cnt_q + 32'd1;
    end
  end

  assign stat_bubble = bubble_cnt_q;
  assign stat_flush  = flush_cnt_q;
`else
  assign stat_bubble = '0;
  assign stat_flush  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: bubble (dut0) and hold (dut1) variants share stimulus;
// a reference model pushes expected states to per-DUT queues popped after each edge.
module tb_pipe_stage_reg;
  localparam int PW = 128;

  typedef struct packed {
    logic          valid;
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic [PW-1:0] payload;
    logic [4:0]    exc;
    logic          bd;
    logic [31:0]   sb;
    logic [31:0]   sf;
  } st_t;

  logic          clk = 1'b0;
  logic          reset, req, stall, in_valid, in_ri, in_bd;
  logic [31:0]   in_pc, in_instr;
  logic [PW-1:0] in_payload;
  logic [4:0]    in_exc;

  logic          v0, v1, bd0, bd1;
  logic [31:0]   pc0, pc1, ins0, ins1, sb0, sb1, sf0, sf1;
  logic [PW-1:0] pl0, pl1;
  logic [4:0]    ex0, ex1;

  st_t q0[$], q1[$];
  st_t m0, m1, e0, e1;
  int  n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.PAYLOAD_W(PW), .HOLD_ON_STALL(1'b0)) dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .in_payload(in_payload), .in_exc(in_exc), .in_ri(in_ri), .in_bd(in_bd),
    .out_valid(v0), .out_pc(pc0), .out_instr(ins0), .out_payload(pl0), .out_exc(ex0),
    .out_bd(bd0), .stat_bubble(sb0), .stat_flush(sf0)
  );

  pipe_stage_reg #(.PAYLOAD_W(PW), .HOLD_ON_STALL(1'b1)) dut_h (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .in_payload(in_payload), .in_exc(in_exc), .in_ri(in_ri), .in_bd(in_bd),
    .out_valid(v1), .out_pc(pc1), .out_instr(ins1), .out_payload(pl1), .out_exc(ex1),
    .out_bd(bd1), .stat_bubble(sb1), .stat_flush(sf1)
  );

  function automatic st_t act0();
    return '{v0, pc0, ins0, pl0, ex0, bd0, sb0, sf0};
  endfunction

  function automatic st_t act1();
    return '{v1, pc1, ins1, pl1, ex1, bd1, sb1, sf1};
  endfunction

  // Reference model of one clock edge.
  function automatic st_t model(st_t cur, bit hold);
    st_t n = cur;
    bit  bub = 1'b0, fl = 1'b0;
    if (reset) return '0;
    if (req) begin
      n.valid = 0; n.pc = 32'h0000_4180; n.instr = 0; n.payload = 0; n.exc = 0; n.bd = 0;
      fl = 1'b1;
    end else if (stall) begin
      if (!hold) begin
        n.valid = 0; n.pc = in_pc; n.instr = 0; n.payload = 0; n.exc = 0; n.bd = in_bd;
        bub = 1'b1;
      end
    end else begin
      n.valid = in_valid; n.pc = in_pc; n.payload = in_payload; n.bd = in_bd;
      n.instr = 0; n.exc = 0;
      if (!in_valid) bub = 1'b1;
      else if (in_exc != 0) n.exc = in_exc;
      else if (in_ri) n.exc = 5'd10;
      else n.instr = in_instr;
    end
`ifdef PIPE_STAGE_STAT_EN
    if (bub) n.sb = cur.sb + 32'd1;
    if (fl)  n.sf = cur.sf + 32'd1;
`else
    n.sb = 0; n.sf = 0;
    if (bub || fl) n.sb = 0;
`endif
    return n;
  endfunction

  task automatic drive(input bit r, input bit rq, input bit st, input bit v, input logic [31:0] pc,
                       input logic [31:0] ins, input logic [4:0] ex, input bit ri, input bit bd);
    reset = r; req = rq; stall = st; in_valid = v; in_pc = pc; in_instr = ins;
    in_exc = ex; in_ri = ri; in_bd = bd;
    in_payload = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Advance one edge, pushing model predictions for both variants.
  task automatic cycle();
    m0 = model(m0, 1'b0);
    m1 = model(m1, 1'b1);
    q0.push_back(m0);
    q1.push_back(m1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 32'h1234, 32'h1, 5'd3, 1, 1);
    cycle();
    e0 = q0.pop_front(); e1 = q1.pop_front(); n_cmp += 3;
    if (act0() !== e0) begin n_err++; $display("FAIL reset0 got %h want %h", act0(), e0); end
    if (act1() !== e1) begin n_err++; $display("FAIL reset1 got %h want %h", act1(), e1); end
    if (pc0 !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", pc0); end
  endtask

  task automatic test_normal_load();
    drive(0, 0, 0, 1, 32'h3000, 32'h2401_0005, 5'd0, 0, 0);
    cycle();
    e0 = q0.pop_front(); e1 = q1.pop_front(); n_cmp += 4;
    if (act0() !== e0) begin n_err++; $display("FAIL load0 got %h want %h", act0(), e0); end
    if (act1() !== e1) begin n_err++; $display("FAIL load1 got %h want %h", act1(), e1); end
    if ({v0, pc0, ins0, ex0} !== {1'b1, 32'h3000, 32'h2401_0005, 5'd0}) begin
      n_err++; $display("FAIL load_fields got %h want %h", {v0, pc0, ins0, ex0},
                        {1'b1, 32'h3000, 32'h2401_0005, 5'd0});
    end
    if (pl0 !== in_payload) begin n_err++; $display("FAIL load_payload got %h want %h", pl0, in_payload); end
  endtask

  task automatic test_ri_priority();
    logic [4:0] want_exc[3] = '{5'd10, 5'd4, 5'd0};
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(0, 0, 0, 1, 32'h3004, 32'hFC00_0000, 5'd0, 1, 0);
      else if (i == 1) drive(0, 0, 0, 1, 32'h3008, 32'hFC00_0000, 5'd4, 1, 1);
      else drive(0, 0, 0, 0, 32'h300C, 32'h1111_2222, 5'd7, 1, 0);
      cycle();
      e0 = q0.pop_front(); e1 = q1.pop_front(); n_cmp += 3;
      if (act0() !== e0) begin n_err++; $display("FAIL ri0[%0d] got %h want %h", i, act0(), e0); end
      if (act1() !== e1) begin n_err++; $display("FAIL ri1[%0d] got %h want %h", i, act1(), e1); end
      if ({ex0, ins0} !== {want_exc[i], 32'h0}) begin
        n_err++; $display("FAIL ri_exc[%0d] got %h want %h", i, {ex0, ins0}, {want_exc[i], 32'h0});
      end
    end
  endtask

  task automatic test_stall();
    drive(0, 0, 1, 1, 32'h3008, 32'h2401_0005, 5'd0, 0, 1);
    cycle();
    e0 = q0.pop_front(); e1 = q1.pop_front(); n_cmp += 3;
    if (act0() !== e0) begin n_err++; $display("FAIL stall0 got %h want %h", act0(), e0); end
    if (act1() !== e1) begin n_err++; $display("FAIL stall1 got %h want %h", act1(), e1); end
    if ({v0, ins0, pc0, bd0} !== {1'b0, 32'h0, 32'h3008, 1'b1}) begin
      n_err++; $display("FAIL stall_bubble got %h want %h", {v0, ins0, pc0, bd0},
                        {1'b0, 32'h0, 32'h3008, 1'b1});
    end
  endtask

  task automatic test_hold();
    drive(0, 0, 0, 1, 32'h3010, 32'h0000_0021, 5'd0, 0, 0);
    cycle();
    e0 = q0.pop_front(); e1 = q1.pop_front();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 32'h5000 + i * 4, $urandom, 5'(i), i[0], i[0]);
      cycle();
      e0 = q0.pop_front(); e1 = q1.pop_front(); n_cmp += 3;
      if (act0() !== e0) begin n_err++; $display("FAIL hold0[%0d] got %h want %h", i, act0(), e0); end
      if (act1() !== e1) begin n_err++; $display("FAIL hold1[%0d] got %h want %h", i, act1(), e1); end
      if ({v1, pc1, ins1} !== {1'b1, 32'h3010, 32'h0000_0021}) begin
        n_err++; $display("FAIL hold_frozen[%0d] got %h want %h", i, {v1, pc1, ins1},
                          {1'b1, 32'h3010, 32'h0000_0021});
      end
    end
  endtask

  task automatic test_flush();
    drive(0, 1, 1, 1, 32'h3020, 32'h1, 5'd0, 0, 1);
    cycle();
    e0 = q0.pop_front(); e1 = q1.pop_front(); n_cmp += 4;
    if (act0() !== e0) begin n_err++; $display("FAIL flush0 got %h want %h", act0(), e0); end
    if (act1() !== e1) begin n_err++; $display("FAIL flush1 got %h want %h", act1(), e1); end
    if ({pc0, v0, bd0, pc1} !== {32'h4180, 1'b0, 1'b0, 32'h4180}) begin
      n_err++; $display("FAIL flush_pc got %h want %h", {pc0, v0, bd0, pc1},
                        {32'h4180, 1'b0, 1'b0, 32'h4180});
    end
    drive(0, 0, 0, 1, 32'h3024, 32'h2, 5'd0, 0, 0);
    cycle();
    e0 = q0.pop_front(); e1 = q1.pop_front();
    drive(1, 1, 1, 1, 32'h3028, 32'h3, 5'd0, 0, 1);
    cycle();
    e0 = q0.pop_front(); e1 = q1.pop_front();
    if (pc0 !== 32'h0) begin n_err++; $display("FAIL reset_over_req got %h want 0", pc0); end
  endtask

  task automatic test_wrap();
    drive(0, 0, 0, 1, 32'h3030, 32'h4, 5'd0, 0, 0);
`ifdef PIPE_STAGE_STAT_EN
    force dut.flush_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.flush_cnt_q;
    m0.sf = 32'hFFFF_FFFF;
`endif
    drive(0, 1, 0, 1, 32'h3030, 32'h4, 5'd0, 0, 0);
    cycle();
    e0 = q0.pop_front(); e1 = q1.pop_front(); n_cmp += 3;
    if (act0() !== e0) begin n_err++; $display("FAIL wrap0 got %h want %h", act0(), e0); end
    if (act1() !== e1) begin n_err++; $display("FAIL wrap1 got %h want %h", act1(), e1); end
    if (sf0 !== 32'h0) begin n_err++; $display("FAIL wrap_flush got %h want 0", sf0); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), $urandom, $urandom,
            ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
            ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
      cycle();
      e0 = q0.pop_front(); e1 = q1.pop_front(); n_cmp += 3;
      if (act0() !== e0) begin n_err++; $display("FAIL b2b0[%0d] got %h want %h", i, act0(), e0); end
      if (act1() !== e1) begin n_err++; $display("FAIL b2b1[%0d] got %h want %h", i, act1(), e1); end
      if (!v0 && ins0 !== 32'h0) begin n_err++; $display("FAIL b2b_nop[%0d] got %h want 0", i, ins0); end
    end
  endtask

  initial begin
    m0 = '0;
    m1 = '0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_normal_load();
    test_ri_priority();
    test_stall();
    test_hold();
    test_flush();
    test_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter PAYLOAD_W, default 128: width of the generic operand payload (rd1/rd2/imm/lui packed by the instantiating stage).
REQ-002 Parameter HOLD_ON_STALL, default 0: 0 means stall inserts a bubble (downstream-side register); 1 means stall freezes the register (upstream-side register).
REQ-003 Parameter HANDLER_PC, default 32'h0000_4180: PC loaded on exception flush.
REQ-004 Parameter RI_CODE, default 10: exception code substituted for a reserved instruction.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 req  in  1  exception/interrupt flush request.
REQ-008 stall  in  1  hazard stall from the hazard unit.
REQ-009 in_valid  in  1  upstream slot holds a real instruction.
REQ-010 in_pc  in  32  upstream PC.
REQ-011 in_instr  in  32  upstream instruction word.
REQ-012 in_payload  in  PAYLOAD_W  upstream operand bundle.
REQ-013 in_exc  in  5  upstream exception code; 0 means none.
REQ-014 in_ri  in  1  reserved-instruction flag from the decoder.
REQ-015 in_bd  in  1  instruction is in a branch delay slot.
REQ-016 out_valid, out_pc, out_instr, out_payload, out_exc, out_bd  out  1/32/32/PAYLOAD_W/5/1  registered copies of the inputs.
REQ-017 stat_bubble, stat_flush  out  32 each  statistics counters (see Configuration).

Function
REQ-018 Action priority per edge SHALL be reset > req > stall > normal load.
REQ-019 req SHALL clear out_valid, out_instr, out_payload, out_exc and out_bd, and SHALL load out_pc with HANDLER_PC.
REQ-020 With HOLD_ON_STALL=0, stall SHALL clear out_valid, out_instr, out_payload and out_exc, and SHALL load out_pc<=in_pc and out_bd<=in_bd, so that the bubble carries the PC and BD for EPC.
REQ-021 With HOLD_ON_STALL=1, stall SHALL leave every output register unchanged.
REQ-022 On a normal load, out_pc, out_payload, out_bd and out_valid SHALL take the corresponding inputs one cycle later (latency 1).
REQ-023 On a normal load with in_exc!=0, out_exc<=in_exc and out_instr<=0; an earlier-stage exception SHALL win over RI.
REQ-024 On a normal load with in_exc==0 and in_ri=1, out_exc<=RI_CODE and out_instr<=0.
REQ-025 On a normal load with in_exc==0 and in_ri=0, out_exc<=0 and out_instr<=in_instr.
REQ-026 On a normal load with in_valid=0, out_instr<=0 and out_exc<=0 regardless of in_exc and in_ri.
REQ-027 A register with out_valid=0 SHALL always present out_instr==0 (nop).
REQ-028 req and stall asserted together SHALL behave as req alone.

Reset
REQ-029 On reset, every output SHALL be 0, including out_pc=0 and both stat counters.
REQ-030 Reset asserted mid-stall or mid-flush SHALL override that action in the same cycle.
REQ-031 The first non-reset edge SHALL perform the action selected by REQ-018.

Configuration
REQ-032 With macro PIPE_STAGE_STAT_EN defined: stat_bubble SHALL increment on each stall edge with HOLD_ON_STALL=0, or on each normal load with in_valid=0; stat_flush SHALL increment on each req edge.
REQ-033 With PIPE_STAGE_STAT_EN defined, both counters SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-034 Without PIPE_STAGE_STAT_EN, stat_bubble and stat_flush SHALL be constant 0, no counter flops SHALL be synthesised, and the ports SHALL remain present.

Verification
REQ-035 Normal load: in_pc=0x3000, in_instr=0x24010005, in_valid=1, in_exc=0, in_ri=0 -> next cycle out_instr=0x24010005, out_pc=0x3000, out_exc=0, out_valid=1.
REQ-036 RI and priority: in_ri=1, in_exc=0 -> out_exc=10, out_instr=0; then in_ri=1, in_exc=4 -> out_exc=4.
REQ-037 Stall, HOLD_ON_STALL=0: stall=1, in_pc=0x3008, in_bd=1 -> out_valid=0, out_instr=0, out_pc=0x3008, out_bd=1, stat_bubble +1.
REQ-038 Stall, HOLD_ON_STALL=1: load 0x3010, then stall=1 for 3 cycles with changing inputs -> outputs stay at the 0x3010 values throughout.
REQ-039 Simultaneous events: req=1 with stall=1 -> out_pc=0x4180, out_valid=0, out_bd=0, stat_flush +1; reset=1 with req=1 -> out_pc=0.
REQ-040 Counter wrap (macro defined): preload stat_flush to 0xFFFF_FFFF by force, pulse req -> stat_flush=0; with the macro undefined -> stat_flush stays 0.
